// File: rtl/alu_seq_mac_wrapper.sv
// Parametrised ALU wrapper with a shared operand/command bus, a sequential shift-add
// multiplier with optional 2W-bit accumulate, and a two-beat registered result port.
module alu_seq_mac_wrapper #(
    parameter int W     = 8,
    parameter int CNT_W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] ABCmd_i,
    input  logic         LoadA_i,
    input  logic         LoadB_i,
    input  logic         LoadCmd_i,
    output logic [W-1:0] ACC_o,
    output logic         Hi_o,
    output logic         Done_o,
    output logic         Busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_OUT_LO, S_OUT_HI} state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W - 1);

    state_t           state_q;
    logic [W-1:0]     a_q, b_q, hi_word_q;
    logic             mac_q;
    logic [2*W-1:0]   accum_q, prod_q;
    logic [CNT_W-1:0] cnt_q;

    logic [7:0]       cmd_in;
    logic [W-1:0]     op2, res, alu_out, flags_word;
    logic [W:0]       sum;
    logic             cin, arith, ovf, co_out;
    logic [W:0]       step_sum;
    logic [2*W-1:0]   prod_next, mac_sum;

    assign cmd_in = ABCmd_i[7:0];

    // The ALU works on the command still on the bus; it is only registered for the MAC bit.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        op2   = '0;
        cin   = 1'b0;
        arith = 1'b0;
        sum   = '0;
        case (cmd_in[3:0])
            4'd0: begin op2 = b_q;    cin = cmd_in[4]; arith = 1'b1; end
            4'd1: begin op2 = ~b_q;   cin = cmd_in[4]; arith = 1'b1; end
            4'd2: sum = {1'b0, a_q & b_q};
            4'd3: sum = {1'b0, a_q | b_q};
            4'd4: sum = {1'b0, a_q ^ b_q};
            4'd5: sum = {1'b0, a_q};
            4'd6: begin op2 = W'(1);  arith = 1'b1; end
            4'd7: begin op2 = '1;     arith = 1'b1; end
            default: ;
        endcase
        if (arith)
            sum = {1'b0, a_q} + {1'b0, op2} + {{W{1'b0}}, cin};
        res = sum[W-1:0];
        ovf = arith && (a_q[W-1] == op2[W-1]) && (res[W-1] != a_q[W-1]);
        if (cmd_in[5]) begin
            alu_out = {sum[W], res[W-1:1]};
            co_out  = res[0];
        end else begin
            alu_out = res;
            co_out  = sum[W];
        end
        flags_word      = '0;
        flags_word[3:0] = {co_out, ovf, alu_out == '0, alu_out[W-1]};
    end

    // Upper half accumulates A, lower half holds the not-yet-consumed multiplier bits.
    always_comb begin
        step_sum  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, a_q} : '0);
        prod_next = {step_sum, prod_q[W-1:1]};
        mac_sum   = mac_q ? accum_q + prod_next : prod_next;
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            mac_q     <= 1'b0;
            accum_q   <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
            hi_word_q <= '0;
            ACC_o     <= '0;
            Hi_o      <= 1'b0;
            Done_o    <= 1'b0;
            Busy_o    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (LoadCmd_i) begin
                        mac_q  <= cmd_in[6];
                        Busy_o <= 1'b1;
                        if (cmd_in[7]) begin
                            prod_q  <= {{W{1'b0}}, b_q};
                            cnt_q   <= '0;
                            state_q <= S_MUL;
                        end else begin
                            ACC_o     <= alu_out;
                            hi_word_q <= flags_word;
                            Hi_o      <= 1'b0;
                            Done_o    <= 1'b1;
                            state_q   <= S_OUT_LO;
                        end
                    end else begin
                        if (LoadA_i) a_q <= ABCmd_i;
                        if (LoadB_i) b_q <= ABCmd_i;
                    end
                end
                S_MUL: begin
                    prod_q <= prod_next;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        accum_q   <= mac_sum;
                        ACC_o     <= mac_sum[W-1:0];
                        hi_word_q <= mac_sum[2*W-1:W];
                        Hi_o      <= 1'b0;
                        Done_o    <= 1'b1;
                        state_q   <= S_OUT_LO;
                    end
                end
                S_OUT_LO: begin
                    ACC_o   <= hi_word_q;
                    Hi_o    <= 1'b1;
                    state_q <= S_OUT_HI;
                end
                default: begin
                    Hi_o    <= 1'b0;
                    Done_o  <= 1'b0;
                    Busy_o  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_mac_wrapper.sv
// Self-checking bench for alu_seq_mac_wrapper (W=8): directed steps plus random
// commands compared against an arithmetic reference model.
module tb_alu_seq_mac_wrapper;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] ABCmd_i = '0;
    logic         LoadA_i = 1'b0, LoadB_i = 1'b0, LoadCmd_i = 1'b0;
    logic [W-1:0] ACC_o;
    logic         Hi_o, Done_o, Busy_o;

    int checks = 0;
    int errors = 0;

    int m_a = 0, m_b = 0, m_acc = 0;

    alu_seq_mac_wrapper #(.W(W), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .ABCmd_i(ABCmd_i),
        .LoadA_i(LoadA_i), .LoadB_i(LoadB_i), .LoadCmd_i(LoadCmd_i),
        .ACC_o(ACC_o), .Hi_o(Hi_o), .Done_o(Done_o), .Busy_o(Busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed running, expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sx(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Reference: ALU result and flag word from the operand values as plain integers.
    task automatic model_alu(input int a, input int b, input int cmd, output int lo, output int hi);
        int full, sres, res, outv, co, v, ci;
        bit arith;
        ci = (cmd >> 4) & 1;
        arith = 1'b1;
        sres = 0;
        case (cmd & 15)
            0: begin full = a + b + ci;         sres = sx(a) + sx(b) + ci; end
            1: begin full = a + (255 - b) + ci; sres = sx(a) - sx(b) - 1 + ci; end
            6: begin full = a + 1;              sres = sx(a) + 1; end
            7: begin full = a + 255;            sres = sx(a) - 1; end
            2: begin full = a & b; arith = 1'b0; end
            3: begin full = a | b; arith = 1'b0; end
            4: begin full = a ^ b; arith = 1'b0; end
            5: begin full = a;     arith = 1'b0; end
            default: begin full = 0; arith = 1'b0; end
        endcase
        v   = (arith && (sres > 127 || sres < -128)) ? 1 : 0;
        co  = (full >> 8) & 1;
        res = full & 255;
        if (((cmd >> 5) & 1) == 1) begin
            outv = co * 128 + res / 2;
            co   = res & 1;
        end else begin
            outv = res;
        end
        lo = outv;
        hi = co * 8 + v * 4 + ((outv == 0) ? 2 : 0) + ((outv >= 128) ? 1 : 0);
    endtask

    task automatic load_ab(input int a, input int b);
        @(negedge clk);
        ABCmd_i = W'(a); LoadA_i = 1'b1;
        @(negedge clk);
        ABCmd_i = W'(b); LoadA_i = 1'b0; LoadB_i = 1'b1;
        @(negedge clk);
        LoadB_i = 1'b0;
        m_a = a; m_b = b;
    endtask

    // mode 0: plain; 1: Load pulses while busy; 2: LoadA together with LoadCmd
    task automatic run_cmd(input int cmd, input int mode);
        int lo, hi, lat, n;
        if (((cmd >> 7) & 1) == 1) begin
            int p;
            p     = m_a * m_b;
            m_acc = (((cmd >> 6) & 1) == 1) ? (m_acc + p) % 65536 : p;
            lo    = m_acc & 255;
            hi    = (m_acc >> 8) & 255;
            lat   = W;
        end else begin
            model_alu(m_a, m_b, cmd, lo, hi);
            lat = 0;
        end
        @(negedge clk);
        ABCmd_i = W'(cmd); LoadCmd_i = 1'b1;
        if (mode == 2) LoadA_i = 1'b1;
        @(negedge clk);
        LoadCmd_i = 1'b0; LoadA_i = 1'b0;
        n = 0;
        while (!Done_o && n < 40) begin
            check("busy_in_mul", Busy_o, 1);
            if (mode == 1 && n == 2) begin
                ABCmd_i = 8'h55; LoadA_i = 1'b1; LoadB_i = 1'b1; LoadCmd_i = 1'b1;
            end else begin
                LoadA_i = 1'b0; LoadB_i = 1'b0; LoadCmd_i = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        LoadA_i = 1'b0; LoadB_i = 1'b0; LoadCmd_i = 1'b0;
        check("latency", n, lat);
        check("lo_word", ACC_o, lo);
        check("lo_hi_flag", Hi_o, 0);
        check("lo_done", Done_o, 1);
        check("lo_busy", Busy_o, 1);
        @(negedge clk);
        check("hi_word", ACC_o, hi);
        check("hi_hi_flag", Hi_o, 1);
        check("hi_done", Done_o, 1);
        @(negedge clk);
        check("idle_done", Done_o, 0);
        check("idle_hi", Hi_o, 0);
        check("idle_busy", Busy_o, 0);
        check("idle_hold", ACC_o, hi);
    endtask

    initial begin
        // Reset state and idle stability
        repeat (2) @(negedge clk);
        check("rst_acc", ACC_o, 0);
        check("rst_done", Done_o, 0);
        check("rst_busy", Busy_o, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_acc", ACC_o, 0);
        check("idle_done0", Done_o, 0);
        check("idle_busy0", Busy_o, 0);
        check("idle_hi0", Hi_o, 0);

        // ADD with signed overflow
        load_ab(8'h7F, 8'h01);
        run_cmd(8'h00, 0);

        // Full-range multiply
        load_ab(8'hFF, 8'hFF);
        run_cmd(8'h80, 0);

        // Multiply then MAC, then SUB with right shift
        load_ab(3, 4);
        run_cmd(8'h80, 0);
        load_ab(5, 6);
        run_cmd(8'hC0, 0);
        load_ab(8'h10, 8'h01);
        run_cmd(8'h21, 0);

        // Loads during MUL are ignored; A still holds the old value afterwards
        load_ab(7, 9);
        run_cmd(8'h80, 1);
        run_cmd(8'h05, 0);

        // LoadA in the same cycle as LoadCmd is ignored
        run_cmd(8'h05, 2);

        // Loading A and B together gives both the same value
        @(negedge clk);
        ABCmd_i = 8'h0B; LoadA_i = 1'b1; LoadB_i = 1'b1;
        @(negedge clk);
        LoadA_i = 1'b0; LoadB_i = 1'b0;
        m_a = 8'h0B; m_b = 8'h0B;
        run_cmd(8'h04, 0);

        // Reset on the fourth MUL cycle
        load_ab(9, 9);
        @(negedge clk);
        ABCmd_i = 8'hC0; LoadCmd_i = 1'b1;
        @(negedge clk);
        LoadCmd_i = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy_before", Busy_o, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", Busy_o, 0);
        check("mid_rst_acc", ACC_o, 0);
        check("mid_rst_done", Done_o, 0);
        m_a = 0; m_b = 0; m_acc = 0;
        @(negedge clk);
        reset = 1'b0;
        load_ab(2, 3);
        run_cmd(8'hC0, 0);

        // Random operands and commands
        for (int i = 0; i < 30; i++) begin
            load_ab(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            run_cmd(int'($urandom_range(0, 255)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
